// File: rtl/sb_tx_serializer_if.sv
`default_nettype none
// ============================================================================
// Module   : sb_tx_serializer_if
// Purpose  : Shared sideband TX message port. The requester is an LTSM state
//            (SBINIT or any later state) and the responder is the sideband
//            transmit serializer. A message is held stable with valid high
//            until the responder pulses ack for one cycle.
// Revision : 1.0 - initial release
// ============================================================================
interface sb_tx_serializer_if #(
  parameter int MSG_W = 64
);

  logic [MSG_W-1:0] TX_msg_i;        // packed SB_msg_t
  logic             TX_msg_valid_i;  // request, held until acknowledged
  logic             TX_msg_ack_o;    // one-cycle capture pulse

  // Requester side (LTSM state driving the shared port)
  modport master (
    output TX_msg_i,
    output TX_msg_valid_i,
    input  TX_msg_ack_o
  );

  // Serializer side
  modport slave (
    input  TX_msg_i,
    input  TX_msg_valid_i,
    output TX_msg_ack_o
  );

endinterface
`default_nettype wire

// File: rtl/sb_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module   : sb_tx_serializer
// Purpose  : Sideband transmit serializer. Captures one parallel message per
//            valid/ack handshake, shifts it out LSB-first on the sideband
//            data pin with a forwarded clock at clk/2, then holds both pins
//            low for the mandatory dead time before the next capture.
//            All outputs come straight from flops.
// Revision : 1.0 - initial release
// ============================================================================
module sb_tx_serializer #(
  parameter int MSG_W  = 64,  // message width, must be >= 2
  parameter int GAP_UI = 32   // dead time in sideband UI (2 clk cycles each)
) (
  input  wire logic          clk_800MHz,
  input  wire logic          reset,          // asynchronous, active low
  input  wire logic          enable_i,
  sb_tx_serializer_if.slave  tx_if,
  output logic               SB_clkPin_TX_o,
  output logic               SB_dataPin_TX_o,
  output logic               busy_o,
  output logic               tx_done_o
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int C_BIT_W = $clog2(MSG_W);
  localparam int C_GAP_W = $clog2(2 * GAP_UI);

  localparam logic [C_BIT_W-1:0] c_BIT_LAST = C_BIT_W'(MSG_W - 1);
  localparam logic [C_GAP_W-1:0] c_GAP_LAST = C_GAP_W'(2 * GAP_UI - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  state_t             r_state;
  logic               r_phase;     // 1: next edge raises the clock pin
  logic [C_BIT_W-1:0] r_bit_cnt;   // index of the bit currently on the pin
  logic [C_GAP_W-1:0] r_gap_cnt;   // dead-time cycles already elapsed
  // Bit 0 of the shift register IS the data pin. Every path back to IDLE
  // clears the register, so the pin reads 0 whenever no packet is on the wire.
  logic [MSG_W-1:0]   r_shreg;
  logic               r_ack;
  logic               r_clk_pin;
  logic               r_busy;
  logic               r_done;

  // Next-state values
  state_t             w_state_nxt;
  logic               w_phase_nxt;
  logic [C_BIT_W-1:0] w_bit_cnt_nxt;
  logic [C_GAP_W-1:0] w_gap_cnt_nxt;
  logic [MSG_W-1:0]   w_shreg_nxt;
  logic               w_ack_nxt;
  logic               w_clk_pin_nxt;
  logic               w_done_nxt;
  logic               w_busy_nxt;

  // Register every piece of state; async assert, release aligned by the caller
  always_ff @(posedge clk_800MHz or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_phase   <= 1'b0;
      r_bit_cnt <= '0;
      r_gap_cnt <= '0;
      r_shreg   <= '0;
      r_ack     <= 1'b0;
      r_clk_pin <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_phase   <= w_phase_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_gap_cnt <= w_gap_cnt_nxt;
      r_shreg   <= w_shreg_nxt;
      r_ack     <= w_ack_nxt;
      r_clk_pin <= w_clk_pin_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
    end
  end

  // Next-state and next-output decode; pulses and pins default low each cycle
  always_comb begin
    w_state_nxt   = r_state;
    w_phase_nxt   = r_phase;
    w_bit_cnt_nxt = r_bit_cnt;
    w_gap_cnt_nxt = r_gap_cnt;
    w_shreg_nxt   = r_shreg;
    w_ack_nxt     = 1'b0;
    w_clk_pin_nxt = 1'b0;
    w_done_nxt    = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        // Capture puts bit 0 on the pin at the same edge as the ack
        if (enable_i && tx_if.TX_msg_valid_i) begin
          w_shreg_nxt   = tx_if.TX_msg_i;
          w_ack_nxt     = 1'b1;
          w_bit_cnt_nxt = '0;
          w_phase_nxt   = 1'b1;
          w_state_nxt   = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        if (!enable_i) begin
          // Abort: drop the partial packet, pins fall at this edge
          w_shreg_nxt = '0;
          w_phase_nxt = 1'b0;
          w_state_nxt = ST_IDLE;
        end else if (r_phase) begin
          // High half of the UI: raise the forwarded clock, data untouched
          w_clk_pin_nxt = 1'b1;
          w_phase_nxt   = 1'b0;
        end else if (r_bit_cnt == c_BIT_LAST) begin
          // Last bit has been sampled; enter the dead time with pins low
          w_shreg_nxt   = '0;
          w_gap_cnt_nxt = '0;
          w_state_nxt   = ST_GAP;
        end else begin
          // Low half: present the next bit while the clock pin is low
          w_shreg_nxt   = {1'b0, r_shreg[MSG_W-1:1]};
          w_bit_cnt_nxt = r_bit_cnt + 1'b1;
          w_phase_nxt   = 1'b1;
        end
      end

      ST_GAP: begin
        if (!enable_i) begin
          w_state_nxt = ST_IDLE;
        end else if (r_gap_cnt == c_GAP_LAST) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt + 1'b1;
        end
      end

      default: begin
        w_shreg_nxt = '0;
        w_phase_nxt = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  assign tx_if.TX_msg_ack_o = r_ack;
  assign SB_clkPin_TX_o     = r_clk_pin;
  assign SB_dataPin_TX_o    = r_shreg[0];
  assign busy_o             = r_busy;
  assign tx_done_o          = r_done;

endmodule
`default_nettype wire

// File: tb/tb_sb_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sb_tx_serializer
// Purpose  : Scoreboard bench for the sideband TX serializer. Directed
//            stimulus pushes each message expected on the wire; a receiver
//            monitor reassembles bits on clock-pin rises and pops/compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sb_tx_serializer;

  localparam int MSG_W  = 64;
  localparam int GAP_UI = 32;

  logic clk;
  logic reset;
  logic en;
  logic clk_pin;
  logic data_pin;
  logic busy;
  logic done;

  sb_tx_serializer_if #(.MSG_W(MSG_W)) tx_if ();

  sb_tx_serializer #(.MSG_W(MSG_W), .GAP_UI(GAP_UI)) dut (
    .clk_800MHz      (clk),
    .reset           (reset),
    .enable_i        (en),
    .tx_if           (tx_if.slave),
    .SB_clkPin_TX_o  (clk_pin),
    .SB_dataPin_TX_o (data_pin),
    .busy_o          (busy),
    .tx_done_o       (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Scoreboard and counters
  logic [MSG_W-1:0] q_exp[$];
  int n_chk  = 0;
  int n_pass = 0;

  int cyc      = 0;
  int ack_cnt  = 0;
  int done_cnt = 0;
  int rise_cnt = 0;
  int stab_err = 0;
  int rx_bits  = 0;
  int gap_len  = 0;
  int last_gap = -1;
  bit gap_on   = 1'b0;
  logic [MSG_W-1:0] rx_val;
  logic prev_clk  = 1'b0;
  logic prev_data = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Receiver monitor: samples pins mid-cycle, reassembles packets LSB-first
  initial begin
    logic [MSG_W-1:0] e;
    rx_val = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (tx_if.TX_msg_ack_o) ack_cnt++;
      if (done) done_cnt++;
      if (gap_on) begin
        if (done) begin
          last_gap = gap_len;
          gap_on   = 1'b0;
        end else if (busy && !clk_pin && !data_pin) begin
          gap_len++;
        end
      end
      if (clk_pin && prev_clk && (data_pin !== prev_data)) stab_err++;
      if (!busy) rx_bits = 0;
      if (clk_pin && !prev_clk) begin
        rise_cnt++;
        rx_val[rx_bits] = data_pin;
        rx_bits++;
        if (rx_bits == MSG_W) begin
          rx_bits = 0;
          gap_on  = 1'b1;
          gap_len = 0;
          if (q_exp.size() == 0) begin
            chk("unexpected_packet", rx_val, 64'h0);
          end else begin
            e = q_exp.pop_front();
            chk("rx_packet", rx_val, e);
          end
        end
      end
      prev_clk  = clk_pin;
      prev_data = data_pin;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ack(input int limit, output int t);
    bit seen = 1'b0;
    t = -1;
    for (int i = 0; i < limit; i++) begin
      tick();
      if (tx_if.TX_msg_ack_o) begin
        seen = 1'b1;
        t = cyc;
        break;
      end
    end
    if (!seen) chk("ack_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_done(input int limit);
    bit seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      tick();
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk("done_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    int t1, t2, d0, r0, a0;
    bit hit;
    reset = 1'b0;
    en    = 1'b0;
    tx_if.TX_msg_i       = '0;
    tx_if.TX_msg_valid_i = 1'b0;

    // Reset state
    repeat (3) tick();
    chk("rst_ack",  {63'd0, tx_if.TX_msg_ack_o}, 64'd0);
    chk("rst_clk",  {63'd0, clk_pin}, 64'd0);
    chk("rst_data", {63'd0, data_pin}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    reset = 1'b1;
    tick();

    // Single-bit message: one UI high then 63 low, 64 clock rises
    d0 = done_cnt; r0 = rise_cnt;
    q_exp.push_back(64'h0000_0000_0000_0001);
    tx_if.TX_msg_i = 64'h0000_0000_0000_0001;
    tx_if.TX_msg_valid_i = 1'b1;
    en = 1'b1;
    wait_ack(10, t1);
    chk("ack_first_data", {63'd0, data_pin}, 64'd1);
    tx_if.TX_msg_valid_i = 1'b0;
    tick();
    chk("ack_one_cycle", {63'd0, tx_if.TX_msg_ack_o}, 64'd0);
    wait_done(400);
    chk("rises_pkt1", rise_cnt - r0, 64);
    chk("done_pkt1", done_cnt - d0, 1);
    chk("gap_pkt1", last_gap, 2 * GAP_UI);

    // Mixed pattern, checked by the receiver model
    q_exp.push_back(64'hA5A5_5A5A_F0F0_0F0F);
    tx_if.TX_msg_i = 64'hA5A5_5A5A_F0F0_0F0F;
    tx_if.TX_msg_valid_i = 1'b1;
    wait_ack(10, t1);
    tx_if.TX_msg_valid_i = 1'b0;
    wait_done(400);

    // Back-to-back with valid held high: 193-cycle start spacing
    d0 = done_cnt;
    q_exp.push_back(64'h0123_4567_89AB_CDEF);
    q_exp.push_back(64'hFEDC_BA98_7654_3210);
    tx_if.TX_msg_i = 64'h0123_4567_89AB_CDEF;
    tx_if.TX_msg_valid_i = 1'b1;
    wait_ack(10, t1);
    tx_if.TX_msg_i = 64'hFEDC_BA98_7654_3210;
    wait_ack(400, t2);
    tx_if.TX_msg_valid_i = 1'b0;
    chk("b2b_spacing", t2 - t1, 2 * MSG_W + 2 * GAP_UI + 1);
    chk("gap_b2b", last_gap, 2 * GAP_UI);
    wait_done(400);
    chk("done_b2b", done_cnt - d0, 2);

    // Abort at bit 20 via enable drop
    d0 = done_cnt;
    tx_if.TX_msg_i = 64'hFFFF_FFFF_FFFF_FFFF;
    tx_if.TX_msg_valid_i = 1'b1;
    wait_ack(10, t1);
    tx_if.TX_msg_valid_i = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (rx_bits == 20) begin hit = 1'b1; break; end
      tick();
    end
    chk("abort_reached_bit20", {63'd0, hit}, 64'd1);
    en = 1'b0;
    tick();
    chk("abort_clk",  {63'd0, clk_pin}, 64'd0);
    chk("abort_data", {63'd0, data_pin}, 64'd0);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    repeat (200) tick();
    chk("abort_no_done", done_cnt - d0, 0);

    // Fresh packet after abort starts from bit 0
    q_exp.push_back(64'h8000_0000_0000_0003);
    tx_if.TX_msg_i = 64'h8000_0000_0000_0003;
    tx_if.TX_msg_valid_i = 1'b1;
    en = 1'b1;
    wait_ack(10, t1);
    tx_if.TX_msg_valid_i = 1'b0;
    wait_done(400);

    // Valid held while disabled: no ack, no activity; enable -> ack next edge
    en = 1'b0;
    a0 = ack_cnt; r0 = rise_cnt;
    q_exp.push_back(64'h0F1E_2D3C_4B5A_6978);
    tx_if.TX_msg_i = 64'h0F1E_2D3C_4B5A_6978;
    tx_if.TX_msg_valid_i = 1'b1;
    repeat (50) tick();
    chk("dis_no_ack", ack_cnt - a0, 0);
    chk("dis_no_rise", rise_cnt - r0, 0);
    chk("dis_data", {63'd0, data_pin}, 64'd0);
    en = 1'b1;
    tick();
    chk("en_ack_next_edge", {63'd0, tx_if.TX_msg_ack_o}, 64'd1);
    tx_if.TX_msg_valid_i = 1'b0;
    wait_done(400);

    // Reset mid-SHIFT: outputs drop before the next clock edge
    tx_if.TX_msg_i = 64'h5555_5555_5555_5555;
    tx_if.TX_msg_valid_i = 1'b1;
    wait_ack(10, t1);
    tx_if.TX_msg_valid_i = 1'b0;
    repeat (30) tick();
    #2 reset = 1'b0;
    #1;
    chk("arst_clk_or_data", {62'd0, clk_pin, data_pin}, 64'd0);
    chk("arst_busy", {63'd0, busy}, 64'd0);
    chk("arst_ack_done", {62'd0, tx_if.TX_msg_ack_o, done}, 64'd0);
    repeat (3) tick();
    reset = 1'b1;
    a0 = ack_cnt; r0 = rise_cnt;
    repeat (20) tick();
    chk("post_rst_no_ack", ack_cnt - a0, 0);
    chk("post_rst_no_rise", rise_cnt - r0, 0);
    chk("post_rst_busy", {63'd0, busy}, 64'd0);

    chk("scoreboard_empty", q_exp.size(), 0);
    chk("data_stable_clk_high", stab_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
